// File: rtl/osd_candidate_reader_if.sv
// Bundle of the OSD candidate reader: upstream candidate bus, downstream
// candidate stream with valid/ready, and the end-of-walk best-candidate report.
interface osd_candidate_reader_if #(
  parameter int K = 8,
  parameter int W = 4
);
  localparam int TOTAL  = K + K*(K-1)/2;
  localparam int IDX_W  = $clog2(TOTAL+1);
  localparam int COST_W = W + $clog2(K+1);

  logic                 start;
  logic                 cands_done;
  logic [TOTAL*K-1:0]   candidates;
  logic [31:0]          candidate_count;
  logic [K-1:0]         a1k_flat;
  logic [K*W-1:0]       rel_flat;
  logic [K-1:0]         cand_out;
  logic [IDX_W-1:0]     cand_index;
  logic                 cand_valid;
  logic                 cand_ready;
  logic                 busy;
  logic [K-1:0]         best_candidate;
  logic [IDX_W-1:0]     best_index;
  logic [COST_W-1:0]    best_cost;
  logic                 best_valid;
  logic                 done;

  // The reader drives the stream and the report; master is the reader side.
  modport master (
    input  start, cands_done, candidates, candidate_count, a1k_flat, rel_flat,
           cand_ready,
    output cand_out, cand_index, cand_valid, busy, best_candidate, best_index,
           best_cost, best_valid, done
  );

  modport slave (
    output start, cands_done, candidates, candidate_count, a1k_flat, rel_flat,
           cand_ready,
    input  cand_out, cand_index, cand_valid, busy, best_candidate, best_index,
           best_cost, best_valid, done
  );
endinterface

// File: rtl/osd_candidate_reader.sv
// Walks the OSD flipping-component candidates in index order, streams each one
// downstream and tracks the minimum soft-flip-cost candidate of the walk.
module osd_candidate_reader #(
  parameter int K      = 8,
  parameter int W      = 4,
  parameter int TOTAL  = K + K*(K-1)/2,
  parameter int COST_W = W + $clog2(K+1),
  parameter int IDX_W  = $clog2(TOTAL+1)
) (
  input logic clk,
  input logic rst,
  osd_candidate_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last_idx;

  function automatic logic [IDX_W-1:0] clamp_count(input logic [31:0] cnt);
    if (cnt > 32'(TOTAL)) return IDX_W'(TOTAL);
    return cnt[IDX_W-1:0];
  endfunction

  // Sum of reliabilities over the MRI positions the candidate flipped.
  function automatic logic [COST_W-1:0] flip_cost(
    input logic [K-1:0]   cand,
    input logic [K-1:0]   a1k,
    input logic [K*W-1:0] rel
  );
    logic [COST_W-1:0] acc;
    acc = '0;
    for (int j = 0; j < K; j++) begin
      if (cand[j] ^ a1k[j]) acc = acc + {{(COST_W-W){1'b0}}, rel[j*W +: W]};
    end
    return acc;
  endfunction

  // Explicit mux keeps the index in range even when it runs one past TOTAL.
  function automatic logic [K-1:0] cand_at(
    input logic [TOTAL*K-1:0] flat,
    input logic [IDX_W-1:0]   i
  );
    logic [K-1:0] c;
    c = '0;
    for (int t = 0; t < TOTAL; t++) begin
      if (i == IDX_W'(t)) c = flat[t*K +: K];
    end
    return c;
  endfunction

  logic              hs_p0;
  logic [COST_W-1:0] cost_p0;
  logic [IDX_W-1:0]  idx_next;
  logic [IDX_W-1:0]  n_start;

  assign hs_p0    = (state == STREAM) && bus.cand_valid && bus.cand_ready;
  assign cost_p0  = flip_cost(bus.cand_out, bus.a1k_flat, bus.rel_flat);
  assign idx_next = bus.cand_index + 1'b1;
  assign n_start  = clamp_count(bus.candidate_count);

  // ---- walk FSM: handshake stage p0 feeds the registered best-candidate state
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      last_idx           <= '0;
      bus.cand_out       <= '0;
      bus.cand_index     <= '0;
      bus.cand_valid     <= 1'b0;
      bus.busy           <= 1'b0;
      bus.best_candidate <= '0;
      bus.best_index     <= '0;
      bus.best_cost      <= '1;
      bus.best_valid     <= 1'b0;
      bus.done           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start && bus.cands_done) begin
            bus.busy           <= 1'b1;
            bus.best_candidate <= '0;
            bus.best_index     <= '0;
            bus.best_cost      <= '1;
            bus.best_valid     <= 1'b0;
            last_idx           <= n_start - 1'b1;
            if (n_start == '0) begin
              state <= FINISH;
            end else begin
              state          <= STREAM;
              bus.cand_valid <= 1'b1;
              bus.cand_index <= '0;
              bus.cand_out   <= cand_at(bus.candidates, '0);
            end
          end
        end

        STREAM: begin
          if (hs_p0) begin
            // Strict less-than keeps the earliest index on equal cost.
            if (!bus.best_valid || (cost_p0 < bus.best_cost)) begin
              bus.best_candidate <= bus.cand_out;
              bus.best_index     <= bus.cand_index;
              bus.best_cost      <= cost_p0;
              bus.best_valid     <= 1'b1;
            end
            if (bus.cand_index == last_idx) begin
              bus.cand_valid <= 1'b0;
              state          <= FINISH;
            end else begin
              bus.cand_index <= idx_next;
              bus.cand_out   <= cand_at(bus.candidates, idx_next);
            end
          end
        end

        FINISH: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_candidate_reader.sv
// Randomized and directed bench for osd_candidate_reader with a cost/argmin reference model.
module tb_osd_candidate_reader;
  localparam int K      = 4;
  localparam int W      = 4;
  localparam int TOTAL  = 10;
  localparam int ALL1   = 127;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  osd_candidate_reader_if #(.K(K), .W(W)) bus();
  osd_candidate_reader #(.K(K), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  int tests = 0;
  int fails = 0;

  logic [K-1:0] cands [TOTAL];
  logic [K-1:0] a1k;
  int           rel [K];

  int           hs_idx [$];
  logic [K-1:0] hs_val [$];
  int stab_err, busy_err, done_cyc, last_hs;
  int exp_n, exp_bi, exp_bc;
  bit exp_bv;

  task automatic load_bus();
    for (int i = 0; i < TOTAL; i++) bus.candidates[i*K +: K] = cands[i];
    bus.a1k_flat = a1k;
    for (int j = 0; j < K; j++) bus.rel_flat[j*W +: W] = 4'(rel[j]);
  endtask

  function automatic int mcost(input int i);
    int s;
    s = 0;
    for (int j = 0; j < K; j++)
      if (((cands[i] >> j) & 1) != ((a1k >> j) & 1)) s += rel[j];
    return s;
  endfunction

  task automatic model(input int count);
    exp_n  = (count > TOTAL) ? TOTAL : count;
    exp_bv = 0; exp_bc = ALL1; exp_bi = 0;
    for (int i = 0; i < exp_n; i++) begin
      if (!exp_bv || mcost(i) < exp_bc) begin
        exp_bv = 1; exp_bc = mcost(i); exp_bi = i;
      end
    end
  endtask

  // Start a walk in the current cycle (cycle 0) and follow it to done.
  task automatic do_walk(input int count, input int pct, input int start_again);
    logic [K-1:0] prev_out;
    int prev_idx;
    bit prev_hold, rdy;
    hs_idx.delete(); hs_val.delete();
    stab_err = 0; busy_err = 0; done_cyc = -1; last_hs = 0;
    prev_hold = 0; prev_out = '0; prev_idx = 0;
    bus.candidate_count = count;
    bus.cands_done = 1'b1;
    bus.start = 1'b1;
    bus.cand_ready = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      bus.start = (cyc == start_again);
      if (prev_hold && (bus.cand_valid !== 1'b1 || bus.cand_out !== prev_out ||
                        int'(bus.cand_index) != prev_idx)) stab_err++;
      if (bus.done === 1'b1) begin
        if (bus.busy !== 1'b0) busy_err++;
        done_cyc = cyc;
        break;
      end
      if (bus.busy !== 1'b1) busy_err++;
      rdy = ($urandom_range(99) < pct);
      bus.cand_ready = rdy;
      if (bus.cand_valid === 1'b1) begin
        if (rdy) begin
          hs_idx.push_back(int'(bus.cand_index));
          hs_val.push_back(bus.cand_out);
          last_hs = cyc;
        end
        prev_hold = !rdy;
        prev_out  = bus.cand_out;
        prev_idx  = int'(bus.cand_index);
      end else begin
        prev_hold = 0;
      end
    end
    bus.cand_ready = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic set_nominal();
    logic [K-1:0] tbl [TOTAL];
    tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
            4'b0101, 4'b1001, 4'b0110, 4'b1010, 4'b1100};
    for (int i = 0; i < TOTAL; i++) cands[i] = tbl[i];
    a1k = 4'b0000;
    for (int j = 0; j < K; j++) rel[j] = j + 1;
    load_bus();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if ({bus.cand_valid, bus.busy, bus.done, bus.best_valid} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags got=%b want=0000", {bus.cand_valid, bus.busy, bus.done, bus.best_valid}); end
    tests++; if (int'(bus.best_cost) != ALL1) begin
      fails++; $display("FAIL reset_best_cost got=%0d want=%0d", bus.best_cost, ALL1); end
    tests++; if ({bus.cand_out, bus.cand_index, bus.best_candidate, bus.best_index} !== '0) begin
      fails++; $display("FAIL reset_data got=%h want=0", {bus.cand_out, bus.cand_index, bus.best_candidate, bus.best_index}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    int se;
    set_nominal();
    do_walk(10, 100, 0);
    se = 0;
    foreach (hs_idx[k]) if (hs_idx[k] != k || k >= TOTAL || hs_val[k] !== cands[k]) se++;
    tests++; if (hs_idx.size() != 10) begin fails++; $display("FAIL nom_hs_count got=%0d want=10", hs_idx.size()); end
    tests++; if (se != 0) begin fails++; $display("FAIL nom_sequence got=%0d errors want=0", se); end
    tests++; if (last_hs != 10) begin fails++; $display("FAIL nom_back_to_back last_hs got=%0d want=10", last_hs); end
    tests++; if (done_cyc != 12) begin fails++; $display("FAIL nom_done_cycle got=%0d want=12", done_cyc); end
    tests++; if (busy_err != 0) begin fails++; $display("FAIL nom_busy got=%0d errors want=0", busy_err); end
    tests++; if (bus.best_candidate !== 4'b0001 || bus.best_index !== 4'd0) begin
      fails++; $display("FAIL nom_best got=%b/%0d want=0001/0", bus.best_candidate, bus.best_index); end
    tests++; if (int'(bus.best_cost) != 1 || bus.best_valid !== 1'b1) begin
      fails++; $display("FAIL nom_best_cost got=%0d/%b want=1/1", bus.best_cost, bus.best_valid); end
    @(posedge clk); #1;
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL nom_done_width got=%b want=0", bus.done); end
    repeat (3) @(posedge clk);
    #1;
    tests++; if (int'(bus.best_cost) != 1 || bus.best_index !== 4'd0) begin
      fails++; $display("FAIL nom_best_hold got=%0d/%0d want=1/0", bus.best_cost, bus.best_index); end
  endtask

  task automatic test_random_ready(input int start_again);
    int se;
    set_nominal();
    a1k = 4'b0011;
    for (int j = 0; j < K; j++) rel[j] = 4 - j;
    load_bus();
    model(10);
    do_walk(10, 50, start_again);
    se = 0;
    foreach (hs_idx[k]) if (hs_idx[k] != k || k >= TOTAL || hs_val[k] !== cands[k]) se++;
    tests++; if (hs_idx.size() != exp_n || se != 0) begin
      fails++; $display("FAIL rr_sequence[%0d] got=%0d hs %0d err want=%0d hs 0 err", start_again, hs_idx.size(), se, exp_n); end
    tests++; if (stab_err != 0) begin fails++; $display("FAIL rr_hold_stable got=%0d want=0", stab_err); end
    tests++; if (done_cyc != last_hs + 2) begin
      fails++; $display("FAIL rr_done_cycle got=%0d want=%0d", done_cyc, last_hs + 2); end
    tests++; if (int'(bus.best_index) != exp_bi || int'(bus.best_cost) != exp_bc ||
                 bus.best_candidate !== cands[exp_bi] || bus.best_valid !== exp_bv) begin
      fails++; $display("FAIL rr_best got=%0d/%0d want=%0d/%0d", bus.best_index, bus.best_cost, exp_bi, exp_bc); end
  endtask

  task automatic test_tie();
    set_nominal();
    for (int j = 0; j < K; j++) rel[j] = 2;
    load_bus();
    do_walk(10, 100, 0);
    tests++; if (bus.best_index !== 4'd0 || int'(bus.best_cost) != 2) begin
      fails++; $display("FAIL tie_best got=%0d/%0d want=0/2", bus.best_index, bus.best_cost); end
  endtask

  task automatic test_count_bounds();
    set_nominal();
    do_walk(0, 100, 0);
    tests++; if (hs_idx.size() != 0 || done_cyc != 2) begin
      fails++; $display("FAIL zero_count got=%0d hs done@%0d want=0 hs done@2", hs_idx.size(), done_cyc); end
    tests++; if (bus.best_valid !== 1'b0 || int'(bus.best_cost) != ALL1) begin
      fails++; $display("FAIL zero_best got=%b/%0d want=0/%0d", bus.best_valid, bus.best_cost, ALL1); end
    do_walk(15, 100, 0);
    tests++; if (hs_idx.size() != 10 || done_cyc != 12) begin
      fails++; $display("FAIL over_count got=%0d hs done@%0d want=10 hs done@12", hs_idx.size(), done_cyc); end
  endtask

  task automatic test_reset_mid();
    int bad;
    set_nominal();
    bus.candidate_count = 10; bus.cands_done = 1'b1; bus.start = 1'b1; bus.cand_ready = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (bus.cand_index !== 4'd2 || bus.cand_valid !== 1'b1) begin
      fails++; $display("FAIL mid_progress got=%0d/%b want=2/1", bus.cand_index, bus.cand_valid); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.cand_ready = 1'b0;
    tests++; if ({bus.cand_valid, bus.busy, bus.done, bus.best_valid} !== 4'b0000 || int'(bus.best_cost) != ALL1 ||
                 {bus.cand_out, bus.cand_index, bus.best_candidate, bus.best_index} !== '0) begin
      fails++; $display("FAIL mid_reset_values got=%b/%0d want=0000/%0d", {bus.cand_valid, bus.busy, bus.done, bus.best_valid}, bus.best_cost, ALL1); end
    bad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cand_valid !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL mid_no_done got=%0d active cycles want=0", bad); end
  endtask

  task automatic test_start_without_done();
    int bad;
    bus.cands_done = 1'b0; bus.candidate_count = 10; bus.start = 1'b1;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.busy !== 1'b0 || bus.cand_valid !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    bus.start = 1'b0;
    tests++; if (bad != 0) begin fails++; $display("FAIL start_no_cands_done got=%0d active cycles want=0", bad); end
  endtask

  task automatic test_random();
    int se, cnt, pct;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < TOTAL; i++) cands[i] = 4'($urandom);
      a1k = 4'($urandom);
      for (int j = 0; j < K; j++) rel[j] = $urandom_range(15);
      load_bus();
      cnt = $urandom_range(12);
      pct = $urandom_range(100, 20);
      model(cnt);
      do_walk(cnt, pct, 0);
      se = 0;
      foreach (hs_idx[k]) if (hs_idx[k] != k || k >= TOTAL || hs_val[k] !== cands[k]) se++;
      tests++; if (hs_idx.size() != exp_n || se != 0 || stab_err != 0 || busy_err != 0) begin
        fails++; $display("FAIL rnd%0d_stream got=%0d hs %0d seq %0d hold %0d busy want=%0d hs 0 0 0",
                          it, hs_idx.size(), se, stab_err, busy_err, exp_n); end
      tests++; if (done_cyc != ((exp_n == 0) ? 2 : last_hs + 2)) begin
        fails++; $display("FAIL rnd%0d_done got=%0d want=%0d", it, done_cyc, (exp_n == 0) ? 2 : last_hs + 2); end
      tests++; if (bus.best_valid !== exp_bv || int'(bus.best_cost) != exp_bc ||
                   (exp_bv && (int'(bus.best_index) != exp_bi || bus.best_candidate !== cands[exp_bi]))) begin
        fails++; $display("FAIL rnd%0d_best got=%b/%0d/%0d want=%b/%0d/%0d", it, bus.best_valid,
                          bus.best_index, bus.best_cost, exp_bv, exp_bi, exp_bc); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.cands_done = 1'b0; bus.cand_ready = 1'b0;
    bus.candidate_count = 0; bus.candidates = '0; bus.a1k_flat = '0; bus.rel_flat = '0;
    test_reset();
    test_nominal();
    test_random_ready(0);
    test_random_ready(3);
    test_tie();
    test_count_bounds();
    test_reset_mid();
    test_start_without_done();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/osd_candidate_reader.md
Name: osd_candidate_reader

Overview:
- Consumer end of the OSD flipping-component interface.
- Takes the flat candidate vector and count produced by the flipping component once it signals done, and walks the candidates in index order.
- Streams each candidate to the downstream re-encoder over a valid/ready handshake.
- Computes each candidate's soft flip cost (sum of reliabilities of flipped MRI bits) and reports the minimum-cost candidate when the walk ends.

Parameters:
- K, 8: information length, bits per candidate.
- TOTAL, K + K*(K-1)/2: maximum number of candidates on the flat bus.
- W, 4: width of each per-bit reliability magnitude (unsigned).
- COST_W, W + $clog2(K+1): cost accumulator width; cannot overflow.
- IDX_W, $clog2(TOTAL+1): width of index and count fields.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a walk; accepted only in IDLE with cands_done=1.
- cands_done  input  1  flipping component done; candidates/candidate_count stable while high.
- candidates  input  TOTAL*K  flat candidate bus; candidate i at bits [i*K +: K].
- candidate_count  input  32  number of valid candidates on the bus.
- a1k_flat  input  K  MRI hard decision the candidates were flipped from.
- rel_flat  input  K*W  reliability of MRI bit j at bits [j*W +: W].
- cand_out  output  K  candidate currently offered downstream.
- cand_index  output  IDX_W  index of cand_out.
- cand_valid  output  1  cand_out is valid.
- cand_ready  input  1  downstream accepts cand_out this cycle.
- busy  output  1  high from accepted start until done.
- best_candidate  output  K  minimum-cost candidate of the last walk.
- best_index  output  IDX_W  its index.
- best_cost  output  COST_W  its cost.
- best_valid  output  1  at least one candidate was evaluated in the last walk.
- done  output  1  one-cycle pulse at end of walk.

Behaviour:
- Reset values: cand_out=0, cand_index=0, cand_valid=0, busy=0, best_candidate=0, best_index=0, best_cost=all-ones, best_valid=0, done=0, FSM=IDLE.
- rst has priority over all other inputs in every state; reset mid-walk aborts immediately with no done pulse.
- States: IDLE, STREAM, FINISH.
- IDLE:
  - start=1 and cands_done=1: latch n = min(candidate_count, TOTAL); clear best_* to reset values; busy=1.
  - n=0: go to FINISH.
  - n>0: go to STREAM with idx=0.
  - start without cands_done is ignored.
- STREAM:
  - cand_valid=1, cand_out=candidates[idx*K +: K], cand_index=idx.
  - cand_out and cand_index hold stable while cand_ready=0.
  - Handshake when cand_valid & cand_ready.
  - On handshake, cost = sum over j of rel_j where (cand_out ^ a1k_flat)[j]=1 (combinational, zero-extended to COST_W).
  - If cost < best_cost or best_valid=0: update best_* from the accepted candidate; best_valid=1. Ties keep the earlier index.
  - After handshake on idx=n-1: cand_valid=0 next cycle; go to FINISH. Otherwise idx+1; the next candidate is offered the cycle after the handshake, so back-to-back acceptance gives 1 candidate/cycle.
  - start is ignored while busy.
  - Inputs are sampled live; the upstream keeps them stable while busy. A drop of cands_done mid-walk is not checked.
- FINISH:
  - done=1 for exactly one cycle; busy=0 in that same cycle.
  - best_* are valid when done=1; go to IDLE.
- best_* hold until the next accepted start or rst.
- Latency: accepted start to first cand_valid = 1 cycle. Last handshake to done = 1 cycle. With n>0 and ready held high, start to done = n+2 cycles.

Test Plan:
- Nominal walk, ready held high: K=4, TOTAL=10, a1k=4'b0000, rel bits0..3 = 1,2,3,4, candidates 0001,0010,0100,1000,0011,0101,1001,0110,1010,1100, count=10 -> cand_index 0..9 on consecutive cycles; done at cycle 12 after start; best_candidate=0001, best_index=0, best_cost=1, best_valid=1.
- Same setup with a1k=4'b0011 and reversed rel (4,3,2,1); pseudo-random cand_ready at 50% -> each candidate is held until accepted; no index is skipped or repeated; best equals the minimum over the computed costs with the earliest index on ties.
- All rel=2 -> ten candidates cost 2 or 4; best_index=0, best_cost=2 (tie rule).
- count=0 -> no cand_valid; done pulses 2 cycles after start; best_valid=0, best_cost=all-ones. count=15 -> exactly 10 handshakes.
- rst asserted after 3 handshakes -> next cycle all outputs at reset values, no done. start with cands_done=0 -> stays IDLE. start pulsed during STREAM -> ignored.
